uart_bus_responder: RTL and testbench
=====================================

// Module: uart_bus_responder
// PURPOSE
// - Memory-mapped UART peripheral: bus responder to the CPU's MEM-stage load/store port (rd/wr/addr/wdata/rdata).
// - Serialises CPU-written bytes onto UART_TX and deserialises UART_RX into a read register.
// - Raises irqout for TX-complete and RX-ready events.
// - Frame format 8N1, LSB first. Single clock domain: clk, the CPU pipeline clock.
// PARAMETERS
// - CLK_DIV    217             clk cycles per bit (25 MHz / 115200); legal range >= 4.
// - BASE_ADDR  32'h4000_0018   address of TXD. RXD = BASE+4, CON = BASE+8; full 32-bit match.
// PORTS
// - clk      in   1   pipeline clock; all state changes on posedge.
// - reset    in   1   asynchronous, active-low reset.
// - rd       in   1   load strobe; qualified by addr.
// - wr       in   1   store strobe; qualified by addr.
// - addr     in   32  byte address.
// - wdata    in   32  store data; only [7:0] is used.
// - rdata    out  32  combinational read data, valid in the same cycle as rd.
// - irqout   out  1   level interrupt to the CPU.
// - UART_RX  in   1   serial input, asynchronous to clk.
// - UART_TX  out  1   serial output; idles high.
// BEHAVIOUR
// - Reset (reset=0): UART_TX=1, irqout=0, all CON bits 0, TXD/RXD 0, both FSMs IDLE.
//   Reset mid-frame aborts the frame immediately.
// - Register map:
//   - TXD (RW): a write loads [7:0] and starts TX if tx_busy=0; it is ignored if tx_busy=1. A read returns the last accepted byte.
//   - RXD (RO): returns {24'd0, rx_data}. A read with rd=1 clears rx_ready at that clock edge.
//   - CON:
//     - [0] tx_irq_en RW; [1] rx_irq_en RW.
//     - [2] tx_done: sticky; cleared by a CON read.
//     - [3] rx_ready RO; [4] tx_busy RO.
//     - [5] rx_overrun: sticky; cleared by a CON read.
//     - [6] frame_err: sticky; cleared by a CON read.
//     - Writes update only [1:0] (and [7] under the macro).
//   - Unmapped address: rdata=0; writes have no effect. rd&wr in the same cycle: rdata shows the pre-write value.
// - irqout = (tx_irq_en & tx_done) | (rx_irq_en & rx_ready), registered: 1-cycle latency from the flag.
// - TX FSM: IDLE -> START -> DATA(8) -> STOP -> IDLE; each state lasts CLK_DIV cycles.
//   - UART_TX is registered. The start bit drives low from the edge after the write-accept edge.
//   - tx_busy=1 from the accept edge through the last STOP cycle.
//   - The edge leaving STOP sets tx_done and clears tx_busy. A write in that same cycle is ignored.
// - RX: 2-flop synchronizer, then FSM IDLE -> START -> DATA(8) -> STOP -> IDLE.
//   - IDLE: a falling edge arms a CLK_DIV/2 counter (integer divide).
//   - START: the line must still be low at mid-bit, else return to IDLE (glitch reject, no flags).
//   - DATA: sample every CLK_DIV cycles at mid-bit, shifting LSB first.
//   - STOP = 1: rx_data <= shifted byte, rx_ready <= 1. If rx_ready was already 1, also set rx_overrun (the new byte overwrites).
//   - STOP = 0: byte discarded, frame_err <= 1, rx_ready unchanged.
// - Same-cycle collisions (flag set wins):
//   - RXD read while a byte completes: rx_ready stays 1, no overrun.
//   - CON read while tx_done/overrun/frame_err is set: the bit stays 1.
// - Bit counters: $clog2(CLK_DIV)+1 bits wide; terminal count CLK_DIV-1, then wrap to 0.
// CONFIGURATION
// - UART_LOOPBACK_EN defined: CON[7] = loopback (RW, reset 0).
//   - When 1, the RX synchronizer input is the internal TX register and UART_RX is ignored.
//   - UART_TX is still driven normally.
// - UART_LOOPBACK_EN undefined: CON[7] reads 0, writes to it are ignored, RX always uses UART_RX.
// TESTING (CLK_DIV=16, BASE_ADDR default)
// - Reset: reset=0 mid-TX frame -> UART_TX=1, irqout=0 immediately; after release, CON read = 0x0.
// - Write TXD=0xA5 ->
//   - start bit low for 16 clk;
//   - data bits 1,0,1,0,0,1,0,1, then stop high, each 16 clk;
//   - CON[4]=1 throughout; then CON[2]=1;
//   - with CON[0]=1, irqout=1 one clk later; a CON read clears it.
// - Drive an RX frame of 0x3C with CON[1]=1 -> CON[3]=1, irqout=1; RXD reads 0x3C; the next CON read shows [3]=0.
// - Two RX frames 0x11 then 0x22 with no read -> CON[5]=1, RXD=0x22.
// - RX frame 0x55 with stop bit low -> CON[6]=1, CON[3]=0. A 4-clk low glitch on UART_RX -> no flags.
// - Write TXD=0x01 then 0x02 while busy -> only 0x01 is transmitted; TXD reads 0x01.
// - UART_LOOPBACK_EN defined, CON=0x82, TXD=0x5A -> RXD=0x5A, CON[3]=1.

Source files
------------

// File: rtl/uart_bus_responder_if.sv
// Load/store bus between the CPU MEM stage and the memory-mapped UART responder.
interface uart_bus_responder_if;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output rd, wr, addr, wdata, input rdata);
    modport slave  (input rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/uart_bus_responder.sv
// Memory-mapped 8N1 UART (TXD/RXD/CON) with TX-done and RX-ready interrupts.
// Optional feature macro: UART_LOOPBACK_EN adds CON[7] internal TX->RX loopback.
module uart_bus_responder #(
    parameter int          CLK_DIV   = 217,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_bus_responder_if.slave   bus,
    output logic                  irqout,
    input  logic                  UART_RX,
    output logic                  UART_TX
);
    localparam int             CW = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0]  TC = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0]  HC = CW'(CLK_DIV / 2 - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          tx_state, rx_state;
    logic [CW-1:0]   tx_cnt, rx_cnt;
    logic [2:0]      tx_bit, rx_bit;
    logic [7:0]      tx_data, rx_data, rx_shift;
    logic            tx_line, tx_busy, tx_done;
    logic            rx_ready, rx_overrun, frame_err;
    logic            tx_irq_en, rx_irq_en, irq_q;
    logic [1:0]      rx_sync;
    logic            rx_prev, rx_line, rx_src, lb_bit;
    logic            unused_wdata;

    logic sel_txd, sel_rxd, sel_con;
    logic txd_wr, con_wr, rxd_rd, con_rd;

    assign sel_txd = (bus.addr == BASE_ADDR);
    assign sel_rxd = (bus.addr == BASE_ADDR + 32'd4);
    assign sel_con = (bus.addr == BASE_ADDR + 32'd8);
    assign txd_wr  = bus.wr & sel_txd;
    assign con_wr  = bus.wr & sel_con;
    assign rxd_rd  = bus.rd & sel_rxd;
    assign con_rd  = bus.rd & sel_con;
    assign rx_line = rx_sync[1];
    assign UART_TX = tx_line;
    assign irqout  = irq_q;

`ifdef UART_LOOPBACK_EN
    logic loopback;
    assign lb_bit       = loopback;
    assign rx_src       = loopback ? tx_line : UART_RX;
    assign unused_wdata = ^bus.wdata[31:8];
`else
    assign lb_bit       = 1'b0;
    assign rx_src       = UART_RX;
    assign unused_wdata = ^bus.wdata[31:7];
`endif

    // Read data reflects current register state, so a same-cycle write is not yet visible
    always_comb begin
        bus.rdata = 32'd0;
        if (sel_txd)
            bus.rdata = {24'd0, tx_data};
        else if (sel_rxd)
            bus.rdata = {24'd0, rx_data};
        else if (sel_con)
            bus.rdata = {24'd0, lb_bit, frame_err, rx_overrun, tx_busy,
                         rx_ready, tx_done, rx_irq_en, tx_irq_en};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_irq_en <= 1'b0;
            rx_irq_en <= 1'b0;
            irq_q     <= 1'b0;
`ifdef UART_LOOPBACK_EN
            loopback  <= 1'b0;
`endif
        end else begin
            if (con_wr) begin
                tx_irq_en <= bus.wdata[0];
                rx_irq_en <= bus.wdata[1];
`ifdef UART_LOOPBACK_EN
                loopback  <= bus.wdata[7];
`endif
            end
            irq_q <= (tx_irq_en & tx_done) | (rx_irq_en & rx_ready);
        end
    end

    // TX line is registered from the current state, so each bit lags its state by one edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_state <= IDLE;
            tx_cnt   <= '0;
            tx_bit   <= 3'd0;
            tx_data  <= 8'd0;
            tx_line  <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            if (con_rd)
                tx_done <= 1'b0;
            case (tx_state)
                IDLE: begin
                    tx_line <= 1'b1;
                    if (txd_wr) begin
                        tx_data  <= bus.wdata[7:0];
                        tx_busy  <= 1'b1;
                        tx_cnt   <= '0;
                        tx_state <= START;
                    end
                end
                START: begin
                    tx_line <= 1'b0;
                    if (tx_cnt == TC) begin
                        tx_cnt   <= '0;
                        tx_bit   <= 3'd0;
                        tx_state <= DATA;
                    end else
                        tx_cnt <= tx_cnt + 1'b1;
                end
                DATA: begin
                    tx_line <= tx_data[tx_bit];
                    if (tx_cnt == TC) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7)
                            tx_state <= STOP;
                        else
                            tx_bit <= tx_bit + 3'd1;
                    end else
                        tx_cnt <= tx_cnt + 1'b1;
                end
                STOP: begin
                    tx_line <= 1'b1;
                    if (tx_cnt == TC) begin
                        tx_cnt   <= '0;
                        tx_busy  <= 1'b0;
                        tx_done  <= 1'b1;
                        tx_state <= IDLE;
                    end else
                        tx_cnt <= tx_cnt + 1'b1;
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

    // Flag sets are written after the bus-read clears so a same-edge event keeps its flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_sync    <= 2'b11;
            rx_prev    <= 1'b1;
            rx_state   <= IDLE;
            rx_cnt     <= '0;
            rx_bit     <= 3'd0;
            rx_shift   <= 8'd0;
            rx_data    <= 8'd0;
            rx_ready   <= 1'b0;
            rx_overrun <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_sync <= {rx_sync[0], rx_src};
            rx_prev <= rx_line;
            if (rxd_rd)
                rx_ready <= 1'b0;
            if (con_rd) begin
                rx_overrun <= 1'b0;
                frame_err  <= 1'b0;
            end
            case (rx_state)
                IDLE: begin
                    if (rx_prev && !rx_line) begin
                        rx_cnt   <= '0;
                        rx_state <= START;
                    end
                end
                START: begin
                    if (rx_cnt == HC) begin
                        rx_cnt   <= '0;
                        rx_bit   <= 3'd0;
                        rx_state <= rx_line ? IDLE : DATA;
                    end else
                        rx_cnt <= rx_cnt + 1'b1;
                end
                DATA: begin
                    if (rx_cnt == TC) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_line, rx_shift[7:1]};
                        if (rx_bit == 3'd7)
                            rx_state <= STOP;
                        else
                            rx_bit <= rx_bit + 3'd1;
                    end else
                        rx_cnt <= rx_cnt + 1'b1;
                end
                STOP: begin
                    if (rx_cnt == TC) begin
                        rx_cnt   <= '0;
                        rx_state <= IDLE;
                        if (rx_line) begin
                            rx_data  <= rx_shift;
                            rx_ready <= 1'b1;
                            if (rx_ready && !rxd_rd)
                                rx_overrun <= 1'b1;
                        end else
                            frame_err <= 1'b1;
                    end else
                        rx_cnt <= rx_cnt + 1'b1;
                end
                default: rx_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_bus_responder.sv
// Scoreboard bench for uart_bus_responder: register-level model, bus-read and TX-frame monitors.
module tb_uart_bus_responder;
    localparam int          DIV  = 16;
    localparam logic [31:0] BASE = 32'h4000_0018;
    localparam logic [31:0] TXD  = BASE;
    localparam logic [31:0] RXD  = BASE + 32'd4;
    localparam logic [31:0] CON  = BASE + 32'd8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic UART_RX = 1'b1;
    logic UART_TX, irqout;

    uart_bus_responder_if bus();

    uart_bus_responder #(.CLK_DIV(DIV), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .bus(bus), .irqout(irqout),
        .UART_RX(UART_RX), .UART_TX(UART_TX)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    bit mon_en = 1'b0;

    typedef struct { string name; logic [31:0] value; } exp_t;
    exp_t       rd_q[$];
    logic [7:0] tx_q[$];

    // Register-level model of the peripheral as seen by software
    bit m_txen, m_rxen, m_done, m_rdy, m_ov, m_fe, m_busy, m_lb;
    logic [7:0] m_txd, m_rxd;
    int acc;

    function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic [31:0] con_model();
        return {24'd0, m_lb, m_fe, m_ov, m_busy, m_rdy, m_done, m_rxen, m_txen};
    endfunction

    function automatic logic irq_model();
        return (m_txen & m_done) | (m_rxen & m_rdy);
    endfunction

    task automatic model_reset();
        {m_txen, m_rxen, m_done, m_rdy, m_ov, m_fe, m_busy, m_lb} = '0;
        m_txd = 8'd0;
        m_rxd = 8'd0;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick(1);
    endtask

    // One bus cycle; the expected read data is queued for the bus monitor
    task automatic applyStimulus(input bit do_rd, input bit do_wr, input logic [31:0] a,
                                 input logic [31:0] d, input string name, input logic [31:0] exp);
        @(posedge clk);
        #1;
        bus.addr  = a;
        bus.wdata = d;
        if (do_rd) rd_q.push_back('{name, exp});
        bus.rd = do_rd;
        bus.wr = do_wr;
        @(posedge clk);
        #1;
        bus.rd = 1'b0;
        bus.wr = 1'b0;
    endtask

    task automatic read_con(input string name);
        applyStimulus(1'b1, 1'b0, CON, 32'd0, name, con_model());
        m_done = 1'b0;
        m_ov   = 1'b0;
        m_fe   = 1'b0;
    endtask

    task automatic read_rxd(input string name);
        applyStimulus(1'b1, 1'b0, RXD, 32'd0, name, {24'd0, m_rxd});
        m_rdy = 1'b0;
    endtask

    task automatic write_con(input logic [7:0] v);
        applyStimulus(1'b0, 1'b1, CON, {24'hABCDEF, v}, "", 32'd0);
        m_txen = v[0];
        m_rxen = v[1];
`ifdef UART_LOOPBACK_EN
        m_lb = v[7];
`endif
    endtask

    task automatic write_txd(input logic [7:0] b);
        bit accept;
        accept = !m_busy;
        if (accept && mon_en) tx_q.push_back(b);
        applyStimulus(1'b0, 1'b1, TXD, {24'h123456, b}, "", 32'd0);
        if (accept) begin
            m_txd  = b;
            m_busy = 1'b1;
            acc    = cyc;
        end
    endtask

    task automatic finish_tx();
        wait_until(acc + 162);
        m_busy = 1'b0;
        m_done = 1'b1;
    endtask

    task automatic send_rx(input logic [7:0] b, input logic stp);
        UART_RX = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            UART_RX = b[i];
            tick(DIV);
        end
        UART_RX = stp;
        tick(DIV);
        UART_RX = 1'b1;
        tick(8);
        if (stp) begin
            if (m_rdy) m_ov = 1'b1;
            m_rdy = 1'b1;
            m_rxd = b;
        end else
            m_fe = 1'b1;
    endtask

    // Bus monitor: whenever a load is presented, compare rdata with the queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (bus.rd === 1'b1) begin
            if (rd_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL rd_unexpected actual=0x%0h expected=none", bus.rdata);
            end else begin
                e = rd_q.pop_front();
                checkOutput(e.name, bus.rdata, e.value);
            end
        end
    end

    // Serial monitor: decode each frame on UART_TX at mid-bit and compare with queued bytes
    initial begin
        logic [7:0] b;
        logic       st, sp;
        forever begin
            @(negedge UART_TX);
            if (!mon_en) continue;
            repeat (8) @(negedge clk);
            st = UART_TX;
            for (int i = 0; i < 8; i++) begin
                repeat (DIV) @(negedge clk);
                b[i] = UART_TX;
            end
            repeat (DIV) @(negedge clk);
            sp = UART_TX;
            checkOutput("tx_start_bit", {31'd0, st}, 32'd0);
            checkOutput("tx_stop_bit", {31'd0, sp}, 32'd1);
            if (tx_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL tx_unexpected_frame actual=0x%0h expected=none", b);
            end else
                checkOutput("tx_frame", {24'd0, b}, {24'd0, tx_q.pop_front()});
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] rb;
        logic [7:0] en;
        bus.rd = 1'b0;
        bus.wr = 1'b0;
        bus.addr = 32'd0;
        bus.wdata = 32'd0;
        model_reset();

        // Reset, then abort a frame mid start bit
        tick(3);
        checkOutput("reset_tx_idle", {31'd0, UART_TX}, 32'd1);
        checkOutput("reset_irq", {31'd0, irqout}, 32'd0);
        reset = 1'b1;
        tick(2);
        write_con(8'h03);
        write_txd(8'($urandom));
        tick(5);
        checkOutput("pre_abort_start_bit", {31'd0, UART_TX}, 32'd0);
        reset = 1'b0;
        #1;
        checkOutput("abort_tx_high", {31'd0, UART_TX}, 32'd1);
        checkOutput("abort_irq_low", {31'd0, irqout}, 32'd0);
        tick(3);
        reset = 1'b1;
        model_reset();
        mon_en = 1'b1;
        tick(2);
        read_con("reset_con");
        applyStimulus(1'b1, 1'b0, TXD, 32'd0, "reset_txd", 32'd0);
        read_rxd("reset_rxd");
        tick(200);

        // Directed TX of 0xA5 with TX interrupt enabled
        write_con(8'h01);
        write_txd(8'hA5);
        checkOutput("tx_accept_edge_idle", {31'd0, UART_TX}, 32'd1);
        tick(1);
        checkOutput("tx_start_first", {31'd0, UART_TX}, 32'd0);
        tick(15);
        checkOutput("tx_start_last", {31'd0, UART_TX}, 32'd0);
        tick(1);
        checkOutput("tx_bit0", {31'd0, UART_TX}, 32'd1);
        read_con("tx_busy_con");
        applyStimulus(1'b1, 1'b0, TXD, 32'd0, "tx_txd_read", {24'd0, m_txd});
        wait_until(acc + 158);
        applyStimulus(1'b1, 1'b0, CON, 32'd0, "tx_last_busy_con", con_model());
        m_busy = 1'b0;
        m_done = 1'b1;
        checkOutput("tx_irq_latency0", {31'd0, irqout}, 32'd0);
        tick(1);
        checkOutput("tx_irq_set", {31'd0, irqout}, 32'd1);
        read_con("tx_done_con");
        tick(2);
        checkOutput("tx_irq_cleared", {31'd0, irqout}, 32'd0);
        read_con("tx_done_cleared_con");

        // Second write while busy is ignored
        write_txd(8'h01);
        write_txd(8'h02);
        applyStimulus(1'b1, 1'b0, TXD, 32'd0, "busy_txd_read", {24'd0, m_txd});
        read_con("busy_con");
        finish_tx();
        read_con("busy_done_con");

        // Directed RX of 0x3C with RX interrupt enabled
        write_con(8'h02);
        send_rx(8'h3C, 1'b1);
        checkOutput("rx_irq_set", {31'd0, irqout}, {31'd0, irq_model()});
        read_con("rx_ready_con");
        read_rxd("rx_data_3c");
        read_con("rx_ready_cleared_con");
        tick(2);
        checkOutput("rx_irq_cleared", {31'd0, irqout}, {31'd0, irq_model()});

        // Overrun, framing error and glitch rejection
        send_rx(8'h11, 1'b1);
        send_rx(8'h22, 1'b1);
        read_con("overrun_con");
        read_rxd("overrun_rxd");
        send_rx(8'h55, 1'b0);
        read_con("frame_err_con");
        read_con("frame_err_cleared_con");
        UART_RX = 1'b0;
        tick(4);
        UART_RX = 1'b1;
        tick(40);
        read_con("glitch_con");
        read_rxd("glitch_rxd");

        // Unmapped accesses and simultaneous read/write
        applyStimulus(1'b0, 1'b1, BASE + 32'd12, 32'hFF, "", 32'd0);
        applyStimulus(1'b1, 1'b0, BASE + 32'd12, 32'd0, "unmapped_rd", 32'd0);
        read_con("unmapped_wr_con");
        applyStimulus(1'b1, 1'b1, CON, 32'h03, "rdwr_pre_value", con_model());
        m_txen = 1'b1;
        m_rxen = 1'b1;
        read_con("rdwr_post_value");

        // Randomized transactions
        for (int it = 0; it < 6; it++) begin
            en = 8'($urandom_range(0, 3));
            write_con(en);
            if ($urandom_range(0, 1) == 1) begin
                write_txd(8'($urandom));
                read_con("rnd_tx_busy_con");
                finish_tx();
                checkOutput("rnd_tx_irq", {31'd0, irqout}, {31'd0, irq_model()});
            end
            for (int f = 0; f < int'($urandom_range(1, 2)); f++) begin
                rb = 8'($urandom);
                send_rx(rb, ($urandom_range(0, 3) != 0));
            end
            checkOutput("rnd_irq", {31'd0, irqout}, {31'd0, irq_model()});
            if ($urandom_range(0, 1) == 1) begin
                en = 8'($urandom_range(0, 3));
                applyStimulus(1'b1, 1'b1, CON, {24'd0, en}, "rnd_rdwr_con", con_model());
                m_txen = en[0];
                m_rxen = en[1];
                m_done = 1'b0;
                m_ov   = 1'b0;
                m_fe   = 1'b0;
            end else
                read_con("rnd_con");
            read_rxd("rnd_rxd");
            applyStimulus(1'b1, 1'b0, BASE + 32'd12 + 32'(4 * $urandom_range(0, 100)),
                          32'd0, "rnd_unmapped", 32'd0);
            tick(2);
            checkOutput("rnd_irq_after_reads", {31'd0, irqout}, {31'd0, irq_model()});
            read_con("rnd_con_final");
        end

`ifdef UART_LOOPBACK_EN
        write_con(8'h82);
        write_txd(8'h5A);
        wait_until(acc + 170);
        m_busy = 1'b0;
        m_done = 1'b1;
        if (m_rdy) m_ov = 1'b1;
        m_rdy = 1'b1;
        m_rxd = 8'h5A;
        read_con("loopback_con");
        read_rxd("loopback_rxd");
        write_con(8'h00);
`else
        write_con(8'h80);
        read_con("no_loopback_con");
`endif

        tick(200);
        checkOutput("tx_queue_drained", 32'(tx_q.size()), 32'd0);
        checkOutput("rd_queue_drained", 32'(rd_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
